mem_sync_top: RTL and testbench
===============================

Name: mem_sync_top

Overview:
- Row-cache tag manager for a DDR3/DDR4 memory emulator.
- Each bank keeps a small fully-associative table of CHROWS entries. Each entry maps a full DRAM row address (RowId) to a local cache-row index (cRowId).
- A read or write access on the currently addressed bank is looked up in that bank's table. A hit returns the index. A miss allocates a free entry. A miss on a full table raises stall until the host asserts sync for that bank, which evicts a victim entry.

Parameters:
- BGWIDTH, 2, bank-group address width; BANKGROUPS = 2**BGWIDTH.
- BAWIDTH, 2, bank address width; BANKSPERGROUP = 2**BAWIDTH.
- CHWIDTH, 6, cache-row index width; CHROWS = 2**CHWIDTH entries per bank.
- ADDRWIDTH, 17, DRAM row address (tag) width.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ba  in  BAWIDTH  bank address selecting the active bank.
- bg  in  BGWIDTH  bank-group address selecting the active group (DDR4 build only; in a DDR3 build bg is absent and treated as 0).
- RowId  in  [BANKGROUPS][BANKSPERGROUP] x ADDRWIDTH  open-row address per bank.
- BankFSM  in  [BANKGROUPS][BANKSPERGROUP] x 5  per-bank protocol state code.
- sync  in  [BANKGROUPS][BANKSPERGROUP] x 1  host finished eviction/fill for that bank.
- cRowId  out  [BANKGROUPS][BANKSPERGROUP] x CHWIDTH  registered cache-row index per bank.
- stall  out  1  registered; 1 while an unresolved full-table miss is pending.

Behaviour:
- State codes: WRITE = 5'b10010, READ = 5'b01011. Every other code means idle (no lookup).
- Per-bank state:
  - valid[CHROWS] and tag[CHROWS] (ADDRWIDTH bits each).
  - fill counter, 0..CHROWS.
  - victim pointer, CHWIDTH bits, round-robin.
- Reset (asynchronous, reset_n=0):
  - all valid cleared, fill counters and victim pointers 0;
  - every cRowId 0, stall 0, no pending miss.
  - Reset asserted mid-operation aborts any pending miss immediately.
- Lookups happen only on the bank selected by {bg,ba}. Each cycle with stall=0 and BankFSM[bg][ba] equal to READ or WRITE, compare RowId[bg][ba] against all valid tags of that bank.
- Hit: cRowId[bg][ba] <= matching index on the next edge. Tables and counters unchanged.
- Miss, fill < CHROWS:
  - tag[fill] <= RowId, valid[fill] <= 1, fill++;
  - cRowId[bg][ba] <= old fill value;
  - no stall.
  - READ misses allocate exactly like WRITE misses (entry data is the host's concern).
- Miss, fill == CHROWS:
  - stall <= 1 on the next edge;
  - latch the pending bank {bg,ba} and its RowId;
  - cRowId unchanged.
- While stall=1:
  - no new lookups;
  - bg/ba/BankFSM changes are ignored;
  - sync of other banks is ignored.
- Resolution: in the first cycle with sync[pending bank]=1:
  - tag[victim] <= latched RowId, valid kept 1;
  - cRowId[pending] <= victim;
  - victim <= victim+1 (wraps CHROWS-1 -> 0);
  - stall <= 0 on that edge.
- sync with no pending miss has no effect.
- Latency: the result is visible 1 cycle after the lookup cycle. Repeating a lookup of the same RowId on following cycles hits and returns the same index.
- Duplicate tags never exist: allocation happens only on a miss.
- Non-selected banks keep their cRowId.

Decomposition:
- Package mem_sync_pkg: WRITE/READ state-code constants and the default width parameters.
- Natural sub-module mem_sync_bank_tags, instantiated once per bank, containing:
  - the tag/valid arrays;
  - the parallel compare yielding hit and index;
  - the fill counter and victim pointer;
  - alloc/replace ports.
- Top level holds the {bg,ba} demux, the pending-miss register, the stall flop and the cRowId registers.

Test Plan:
1. Reset:
   - hold reset_n=0 -> all cRowId=0, stall=0.
   - Release, then WRITE bank(0,0) RowId=0x1234 -> cRowId[0][0]=0 next cycle, stall=0.
2. Fill:
   - 64 WRITEs of distinct random RowIds on bank(0,0) (each held 3 cycles), each followed by a READ of the same RowId.
   - Write i -> cRowId=i; the read -> same i (hit); stall stays 0 throughout.
3. Write miss when full:
   - after scenario 2, WRITE a new RowId -> stall=1 from the next cycle, held for 4 cycles, cRowId unchanged.
   - sync[0][0]=1 for 1 cycle -> stall=0, cRowId[0][0]=0 (victim 0), victim pointer 1.
4. Read miss when full:
   - then READ a new RowId -> stall=1.
   - sync -> cRowId[0][0]=1, stall=0.
   - READ of the scenario-3 RowId -> hit, index 0.
5. Bank isolation:
   - WRITE RowId 0x55 on bank(1,2) -> cRowId[1][2]=0 while cRowId[0][0] is unchanged.
   - sync[1][2] pulsed during a bank(0,0) stall does not clear stall.
6. Reset mid-stall:
   - reset_n=0 while stall=1 -> stall=0 immediately.
   - Previously cached RowIds miss and allocate from index 0 again.

Source files
------------

// File: rtl/mem_sync_pkg.sv
// Shared constants and types for the row-cache tag manager.
// Bank protocol state codes, default widths and the top-level FSM state type.
package mem_sync_pkg;

    localparam int BGWIDTH_DEF   = 2;
    localparam int BAWIDTH_DEF   = 2;
    localparam int CHWIDTH_DEF   = 6;
    localparam int ADDRWIDTH_DEF = 17;

    localparam logic [4:0] BANK_WRITE = 5'b10010;
    localparam logic [4:0] BANK_READ  = 5'b01011;

    typedef enum logic [0:0] {
        ST_LOOKUP = 1'b0,
        ST_STALL  = 1'b1
    } sync_state_e;

    // Only READ and WRITE trigger a tag lookup; every other code is idle.
    function automatic logic is_access(input logic [4:0] code);
        return (code == BANK_WRITE) || (code == BANK_READ);
    endfunction

endpackage

// File: rtl/mem_sync_if.sv
// Host <-> tag manager bus: per-bank row addresses, protocol states and results.
// stall/sync handshake: stall stays high until a rising edge sees sync[] of the pending bank high.
interface mem_sync_if
    import mem_sync_pkg::*;
#(
    parameter int BGWIDTH   = BGWIDTH_DEF,
    parameter int BAWIDTH   = BAWIDTH_DEF,
    parameter int CHWIDTH   = CHWIDTH_DEF,
    parameter int ADDRWIDTH = ADDRWIDTH_DEF
);
    localparam int BANKGROUPS    = 2 ** BGWIDTH;
    localparam int BANKSPERGROUP = 2 ** BAWIDTH;

    logic [BAWIDTH-1:0] ba;
    logic [BGWIDTH-1:0] bg;
    logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][ADDRWIDTH-1:0] RowId;
    logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][4:0]           BankFSM;
    logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0]                sync;
    logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][CHWIDTH-1:0]   cRowId;
    logic                                                    stall;

    modport master (
        output ba, bg, RowId, BankFSM, sync,
        input  cRowId, stall
    );

    modport slave (
        input  ba, bg, RowId, BankFSM, sync,
        output cRowId, stall
    );

endinterface

// File: rtl/mem_sync_bank_tags.sv
// One bank's fully-associative tag table: parallel compare, sequential fill,
// and round-robin victim replacement once the table is full.
module mem_sync_bank_tags
    import mem_sync_pkg::*;
#(
    parameter int CHWIDTH   = CHWIDTH_DEF,
    parameter int ADDRWIDTH = ADDRWIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ADDRWIDTH-1:0] row_id,
    input  logic                 alloc,
    input  logic                 replace,
    input  logic [ADDRWIDTH-1:0] replace_tag,
    output logic                 hit,
    output logic [CHWIDTH-1:0]   hit_idx,
    output logic                 full,
    output logic [CHWIDTH-1:0]   fill_idx,
    output logic [CHWIDTH-1:0]   victim
);
    localparam int CHROWS = 2 ** CHWIDTH;

    logic [ADDRWIDTH-1:0] tag [CHROWS];
    logic [CHROWS-1:0]    valid;
    logic [CHWIDTH:0]     fill;
    logic [CHWIDTH-1:0]   vic;

    // Tags are only ever written on a miss, so at most one entry can match.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < CHROWS; i++) begin
            if (valid[i] && (tag[i] == row_id)) begin
                hit     = 1'b1;
                hit_idx = CHWIDTH'(i);
            end
        end
    end

    assign full     = fill[CHWIDTH];
    assign fill_idx = fill[CHWIDTH-1:0];
    assign victim   = vic;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
            fill  <= '0;
            vic   <= '0;
        end else if (alloc) begin
            valid[fill_idx] <= 1'b1;
            fill            <= fill + 1'b1;
        end else if (replace) begin
            vic <= vic + 1'b1;
        end
    end

    // Tag storage needs no reset: valid gates every compare.
    always_ff @(posedge clk) begin
        if (alloc) begin
            tag[fill_idx] <= row_id;
        end else if (replace) begin
            tag[vic] <= replace_tag;
        end
    end

endmodule

// File: rtl/mem_sync_top.sv
// Row-cache tag manager: routes lookups to the addressed bank, registers cRowId,
// and holds a single pending full-table miss until the host syncs that bank.
module mem_sync_top
    import mem_sync_pkg::*;
#(
    parameter int BGWIDTH   = BGWIDTH_DEF,
    parameter int BAWIDTH   = BAWIDTH_DEF,
    parameter int CHWIDTH   = CHWIDTH_DEF,
    parameter int ADDRWIDTH = ADDRWIDTH_DEF,
    parameter bit DDR4      = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    mem_sync_if.slave   bus,
    output sync_state_e state_dbg
);
    localparam int BANKGROUPS    = 2 ** BGWIDTH;
    localparam int BANKSPERGROUP = 2 ** BAWIDTH;

    sync_state_e          state;
    logic                 stall;
    logic [BGWIDTH-1:0]   pend_g;
    logic [BAWIDTH-1:0]   pend_b;
    logic [ADDRWIDTH-1:0] pend_row;
    logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][CHWIDTH-1:0] crow;

    logic               hit      [BANKGROUPS][BANKSPERGROUP];
    logic [CHWIDTH-1:0] hit_idx  [BANKGROUPS][BANKSPERGROUP];
    logic               full     [BANKGROUPS][BANKSPERGROUP];
    logic [CHWIDTH-1:0] fill_idx [BANKGROUPS][BANKSPERGROUP];
    logic [CHWIDTH-1:0] victim   [BANKGROUPS][BANKSPERGROUP];
    logic               alloc    [BANKGROUPS][BANKSPERGROUP];
    logic               replace  [BANKGROUPS][BANKSPERGROUP];

    logic [BGWIDTH-1:0] sel_g;
    logic [BAWIDTH-1:0] sel_b;
    logic               lookup_en;
    logic               resolve;

    // A DDR3 build has no bank-group pins; every access lands in group 0.
    assign sel_g     = DDR4 ? bus.bg : '0;
    assign sel_b     = bus.ba;
    assign lookup_en = (state == ST_LOOKUP) && is_access(bus.BankFSM[sel_g][sel_b]);
    assign resolve   = (state == ST_STALL) && bus.sync[pend_g][pend_b];

    always_comb begin
        for (int g = 0; g < BANKGROUPS; g++) begin
            for (int b = 0; b < BANKSPERGROUP; b++) begin
                alloc[g][b]   = lookup_en && (sel_g == BGWIDTH'(g)) && (sel_b == BAWIDTH'(b))
                                && !hit[g][b] && !full[g][b];
                replace[g][b] = resolve && (pend_g == BGWIDTH'(g)) && (pend_b == BAWIDTH'(b));
            end
        end
    end

    for (genvar g = 0; g < BANKGROUPS; g++) begin : g_group
        for (genvar b = 0; b < BANKSPERGROUP; b++) begin : g_bank
            mem_sync_bank_tags #(
                .CHWIDTH   (CHWIDTH),
                .ADDRWIDTH (ADDRWIDTH)
            ) u_tags (
                .clk         (clk),
                .reset_n     (reset_n),
                .row_id      (bus.RowId[g][b]),
                .alloc       (alloc[g][b]),
                .replace     (replace[g][b]),
                .replace_tag (pend_row),
                .hit         (hit[g][b]),
                .hit_idx     (hit_idx[g][b]),
                .full        (full[g][b]),
                .fill_idx    (fill_idx[g][b]),
                .victim      (victim[g][b])
            );
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_LOOKUP;
            stall    <= 1'b0;
            pend_g   <= '0;
            pend_b   <= '0;
            pend_row <= '0;
            crow     <= '0;
        end else begin
            case (state)
                ST_LOOKUP: begin
                    if (lookup_en) begin
                        if (hit[sel_g][sel_b]) begin
                            crow[sel_g][sel_b] <= hit_idx[sel_g][sel_b];
                        end else if (!full[sel_g][sel_b]) begin
                            crow[sel_g][sel_b] <= fill_idx[sel_g][sel_b];
                        end else begin
                            state    <= ST_STALL;
                            stall    <= 1'b1;
                            pend_g   <= sel_g;
                            pend_b   <= sel_b;
                            pend_row <= bus.RowId[sel_g][sel_b];
                        end
                    end
                end
                ST_STALL: begin
                    // The victim index returned here is the entry being overwritten this edge.
                    if (resolve) begin
                        crow[pend_g][pend_b] <= victim[pend_g][pend_b];
                        state <= ST_LOOKUP;
                        stall <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_LOOKUP;
                    stall <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cRowId = crow;
    assign bus.stall  = stall;
    assign state_dbg  = state;

endmodule

// File: tb/tb_mem_sync_top.sv
// Directed scenarios plus a random phase, checked every cycle against a
// table-level model of each bank's row cache.
module tb_mem_sync_top;
    import mem_sync_pkg::*;

    localparam int NB     = 16;
    localparam int CHROWS = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_sync_if  bus ();
    sync_state_e state_dbg;

    mem_sync_top dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    int n_asserts = 0;
    int n_fails   = 0;

    // Reference model: per bank, a list of cached rows indexed by cache slot.
    logic [16:0] m_tag [NB][CHROWS];
    bit          m_val [NB][CHROWS];
    int          m_fill [NB];
    int          m_victim [NB];
    int          m_crow [NB];
    bit          m_stall;
    int          m_pend;
    logic [16:0] m_pend_row;

    logic [16:0] used_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NB; k++) begin
            for (int i = 0; i < CHROWS; i++) m_val[k][i] = 1'b0;
            m_fill[k]   = 0;
            m_victim[k] = 0;
            m_crow[k]   = 0;
        end
        m_stall = 1'b0;
        m_pend  = 0;
    endfunction

    function automatic void model_step();
        int k;
        int found;
        logic [4:0]  code;
        logic [16:0] row;
        if (!m_stall) begin
            k    = int'(bus.bg) * 4 + int'(bus.ba);
            code = bus.BankFSM[k/4][k%4];
            row  = bus.RowId[k/4][k%4];
            if (code == BANK_WRITE || code == BANK_READ) begin
                found = -1;
                for (int i = 0; i < CHROWS; i++)
                    if (m_val[k][i] && m_tag[k][i] == row) found = i;
                if (found >= 0) begin
                    m_crow[k] = found;
                end else if (m_fill[k] < CHROWS) begin
                    m_tag[k][m_fill[k]] = row;
                    m_val[k][m_fill[k]] = 1'b1;
                    m_crow[k] = m_fill[k];
                    m_fill[k]++;
                end else begin
                    m_stall    = 1'b1;
                    m_pend     = k;
                    m_pend_row = row;
                end
            end
        end else if (bus.sync[m_pend/4][m_pend%4]) begin
            m_tag[m_pend][m_victim[m_pend]] = m_pend_row;
            m_crow[m_pend]   = m_victim[m_pend];
            m_victim[m_pend] = (m_victim[m_pend] + 1) % CHROWS;
            m_stall = 1'b0;
        end
    endfunction

    task automatic check_all();
        for (int k = 0; k < NB; k++)
            check($sformatf("crow_b%0d", k), 32'(bus.cRowId[k/4][k%4]), 32'(m_crow[k]));
        check("stall", 32'(bus.stall), 32'(m_stall));
        check("state_dbg", 32'(state_dbg), 32'(m_stall ? ST_STALL : ST_LOOKUP));
    endtask

    // Non-selected banks get random noise to prove they are not looked up.
    task automatic drive(input int k, input logic [4:0] fsm, input logic [16:0] row,
                         input logic [15:0] sy);
        for (int j = 0; j < NB; j++) begin
            bus.RowId[j/4][j%4]   = 17'($urandom);
            bus.BankFSM[j/4][j%4] = 5'($urandom);
            bus.sync[j/4][j%4]    = sy[j];
        end
        bus.bg = 2'(k / 4);
        bus.ba = 2'(k % 4);
        bus.BankFSM[k/4][k%4] = fsm;
        bus.RowId[k/4][k%4]   = row;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        drive(0, 5'b00000, 17'h0, 16'h0);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset_n = 1'b1;
    endtask

    function automatic logic [16:0] new_row();
        logic [16:0] r;
        bit dup;
        do begin
            r   = 17'($urandom_range(0, 17'h1ffff));
            dup = 1'b0;
            foreach (used_q[i]) if (used_q[i] == r) dup = 1'b1;
        end while (dup);
        used_q.push_back(r);
        return r;
    endfunction

    logic [16:0] r, r3, r4, r5, r6;

    initial begin
        bus.ba = '0; bus.bg = '0; bus.RowId = '0; bus.BankFSM = '0; bus.sync = '0;
        #2;

        // Reset, then first allocation
        do_reset();
        drive(0, BANK_WRITE, 17'h1234, 16'h0);
        tick();
        check("s1_crow00", 32'(bus.cRowId[0][0]), 32'd0);
        check("s1_stall", 32'(bus.stall), 32'd0);

        // Fill bank(0,0)
        do_reset();
        for (int i = 0; i < CHROWS; i++) begin
            r = new_row();
            drive(0, BANK_WRITE, r, 16'h0);
            repeat (3) tick();
            check("s2_write_idx", 32'(bus.cRowId[0][0]), 32'(i));
            drive(0, BANK_READ, r, 16'h0);
            tick();
            check("s2_read_idx", 32'(bus.cRowId[0][0]), 32'(i));
            check("s2_stall", 32'(bus.stall), 32'd0);
        end

        // Write miss on full table
        r3 = new_row();
        drive(0, BANK_WRITE, r3, 16'h0);
        tick();
        check("s3_stall_set", 32'(bus.stall), 32'd1);
        repeat (4) begin
            tick();
            check("s3_stall_held", 32'(bus.stall), 32'd1);
            check("s3_crow_kept", 32'(bus.cRowId[0][0]), 32'd63);
        end
        drive(0, BANK_WRITE, r3, 16'h0001);
        tick();
        check("s3_stall_clr", 32'(bus.stall), 32'd0);
        check("s3_victim0", 32'(bus.cRowId[0][0]), 32'd0);
        drive(0, 5'b00000, r3, 16'h0);
        tick();

        // Read miss on full table
        r4 = new_row();
        drive(0, BANK_READ, r4, 16'h0);
        tick();
        check("s4_stall_set", 32'(bus.stall), 32'd1);
        drive(0, BANK_READ, r4, 16'h0001);
        tick();
        check("s4_victim1", 32'(bus.cRowId[0][0]), 32'd1);
        check("s4_stall_clr", 32'(bus.stall), 32'd0);
        drive(0, BANK_READ, r3, 16'h0);
        tick();
        check("s4_rehit", 32'(bus.cRowId[0][0]), 32'd0);

        // Bank isolation
        drive(6, BANK_WRITE, 17'h55, 16'h0);
        tick();
        check("s5_crow12", 32'(bus.cRowId[1][2]), 32'd0);
        check("s5_crow00", 32'(bus.cRowId[0][0]), 32'd0);
        r5 = new_row();
        drive(0, BANK_WRITE, r5, 16'h0);
        tick();
        check("s5_stall_set", 32'(bus.stall), 32'd1);
        drive(0, BANK_WRITE, r5, 16'h0040);
        tick();
        check("s5_other_sync", 32'(bus.stall), 32'd1);
        drive(0, BANK_WRITE, r5, 16'h0001);
        tick();
        check("s5_victim2", 32'(bus.cRowId[0][0]), 32'd2);

        // Reset while stalled
        r6 = new_row();
        drive(0, BANK_WRITE, r6, 16'h0);
        tick();
        check("s6_stall_set", 32'(bus.stall), 32'd1);
        drive(0, 5'b00000, 17'h0, 16'h0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("s6_async_clr", 32'(bus.stall), 32'd0);
        check_all();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(0, BANK_WRITE, r3, 16'h0);
        tick();
        check("s6_realloc0", 32'(bus.cRowId[0][0]), 32'd0);
        drive(0, BANK_READ, r4, 16'h0);
        tick();
        check("s6_realloc1", 32'(bus.cRowId[0][0]), 32'd1);

        // Random traffic, concentrated on two banks with a small row space
        for (int n = 0; n < 800; n++) begin
            int k;
            logic [4:0] fsm;
            logic [15:0] sy;
            case ($urandom_range(0, 3))
                0, 1:    k = 0;
                2:       k = 6;
                default: k = $urandom_range(0, NB - 1);
            endcase
            case ($urandom_range(0, 3))
                0:       fsm = BANK_WRITE;
                1:       fsm = BANK_READ;
                2:       fsm = 5'b00000;
                default: fsm = 5'($urandom);
            endcase
            sy = 16'($urandom) & 16'($urandom);
            drive(k, fsm, 17'($urandom_range(0, 99)), sy);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
